// File: rtl/count_display_scan_if.sv
// count_display_scan_if: counter-sample input and 2-digit seven-segment display bundle.
interface count_display_scan_if;
  logic [3:0] count;
  logic       count_valid;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  modport master (output count, count_valid, input seg, an, dp);
  modport slave  (input count, count_valid, output seg, an, dp);
endinterface

// File: rtl/count_display_scan.sv
// count_display_scan: captures a 4-bit count, splits it into BCD and scans two seven-segment digits with blanking gaps.
// Define COUNT_DISP_LZ_BLANK_EN to blank a leading-zero tens digit.
module count_display_scan #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  count_display_scan_if.slave bus
);
  localparam int TW = $clog2(REFRESH_DIV > BLANK_CYC ? REFRESH_DIV : BLANK_CYC);
  typedef enum logic [1:0] {GAP1, ONES, GAP0, TENS} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n, dur;
  logic done, tens_on;
  logic [3:0] cap_val, ones_r;
  logic tens_r, wrap, wrap_r;
  logic [6:0] seg_r, seg_n;
  logic [1:0] an_r, an_n;
  logic dp_r, dp_n;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction
  // wrap_r trails the wrap flag so dp stays aligned with the BCD digits it annotates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_val <= '0;
      wrap    <= 1'b0;
      tens_r  <= 1'b0;
      ones_r  <= '0;
      wrap_r  <= 1'b0;
    end else begin
      if (bus.count_valid) begin
        cap_val <= bus.count;
        wrap    <= bus.count < cap_val;
      end
      tens_r <= cap_val >= 4'd10;
      ones_r <= cap_val >= 4'd10 ? cap_val - 4'd10 : cap_val;
      wrap_r <= wrap;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GAP1;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end
  always_comb begin
    dur     = (state == ONES || state == TENS) ? TW'(REFRESH_DIV - 1) : TW'(BLANK_CYC - 1);
    done    = timer == dur;
    timer_n = done ? '0 : timer + 1'b1;
    state_n = !done ? state : state == GAP1 ? ONES : state == ONES ? GAP0 : state == GAP0 ? TENS : GAP1;
`ifdef COUNT_DISP_LZ_BLANK_EN
    tens_on = tens_r;
`else
    tens_on = 1'b1;
`endif
    an_n  = state_n == ONES ? 2'b01 : (state_n == TENS && tens_on) ? 2'b10 : 2'b00;
    seg_n = an_n[0] ? enc(ones_r) : an_n[1] ? enc({3'b000, tens_r}) : 7'h00;
    dp_n  = an_n[0] && wrap_r;
  end
  // outputs only change on slot-entry edges, so the lit digit is frozen for the whole slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= {7{SEG_ACTIVE_LOW}};
      an_r  <= {2{SEG_ACTIVE_LOW}};
      dp_r  <= SEG_ACTIVE_LOW;
    end else if (done) begin
      seg_r <= seg_n ^ {7{SEG_ACTIVE_LOW}};
      an_r  <= an_n ^ {2{SEG_ACTIVE_LOW}};
      dp_r  <= dp_n ^ SEG_ACTIVE_LOW;
    end
  end
  assign bus.seg = seg_r;
  assign bus.an  = an_r;
  assign bus.dp  = dp_r;
endmodule

// File: tb/tb_count_display_scan.sv
// tb_count_display_scan: directed and randomized checks of the scanned display against a slot-timeline model.
module tb_count_display_scan;
  localparam int R = 8;
  localparam int B = 2;
  localparam int P = 2 * (R + B);
  logic clk = 1'b0;
  logic rst = 1'b1;
  count_display_scan_if bus ();
  count_display_scan #(.REFRESH_DIV(R), .BLANK_CYC(B), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int ncmp = 0;
  int nfail = 0;
  int e = 0;
  int hist [4096];
  logic whist [4096];
  int cap_m = 0;
  logic wrap_m = 1'b0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  function automatic int val_at(input int i);
    return i < 0 ? 0 : hist[i];
  endfunction
  function automatic logic wrap_at(input int i);
    return i < 0 ? 1'b0 : whist[i];
  endfunction
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, got, exp);
    end
  endtask
  task automatic check_model();
    int pos, ent, v;
    logic [6:0] es;
    logic [1:0] ea;
    logic ed;
    pos = e % P;
    es = 7'h00;
    ea = 2'b00;
    ed = 1'b0;
    if (pos >= B && pos < B + R) begin
      ent = e - (pos - B);
      v = val_at(ent - 2);
      es = seg_tab[v % 10];
      ea = 2'b01;
      ed = wrap_at(ent - 2);
    end else if (pos >= 2 * B + R) begin
      ent = e - (pos - 2 * B - R);
      v = val_at(ent - 2);
      es = seg_tab[v / 10];
      ea = 2'b10;
`ifdef COUNT_DISP_LZ_BLANK_EN
      if (v < 10) begin
        es = 7'h00;
        ea = 2'b00;
      end
`endif
    end
    chk("seg", bus.seg, ~es);
    chk("an", {5'b0, bus.an}, {5'b0, ~ea});
    chk("dp", {6'b0, bus.dp}, {6'b0, ~ed});
  endtask
  task automatic step(input logic v, input logic [3:0] c);
    bus.count_valid = v;
    bus.count = c;
    @(posedge clk);
    e++;
    if (v) begin
      wrap_m = int'(c) < cap_m;
      cap_m = int'(c);
    end
    hist[e] = cap_m;
    whist[e] = wrap_m;
    #1;
    bus.count_valid = 1'b0;
    check_model();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_an", {5'b0, bus.an}, 7'h03);
    chk("rst_dp", {6'b0, bus.dp}, 7'h01);
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    cap_m = 0;
    wrap_m = 1'b0;
    hist[0] = 0;
    whist[0] = 1'b0;
  endtask
  task automatic goto_pos(input int p);
    for (int i = 0; i < P + 1 && (e % P) != p; i++) step(1'b0, 4'd0);
  endtask
  initial begin
    logic [3:0] cnt;
    bus.count = 4'd0;
    bus.count_valid = 1'b0;
    cnt = 4'd0;
    do_reset();
    step(1'b0, 4'd0);
    chk("boot_gap_an", {5'b0, bus.an}, 7'h03);
    step(1'b0, 4'd0);
    chk("boot_ones_an", {5'b0, bus.an}, 7'h02);
    chk("boot_ones_seg", bus.seg, 7'h40);
    step(1'b1, 4'd7);
    idle(2 * P);
    step(1'b1, 4'd13);
    idle(2 * P);
    step(1'b1, 4'd15);
    step(1'b1, 4'd0);
    idle(2 * P);
    step(1'b1, 4'd1);
    idle(2 * P);
    step(1'b1, 4'd4);
    idle(P + 5);
    goto_pos(B + 1);
    step(1'b1, 4'd9);
    chk("midslot_hold", bus.seg, 7'h19);
    idle(2 * P);
    step(1'b1, 4'd9);
    idle(3);
    step(1'b1, 4'd9);
    idle(2 * P);
    goto_pos(2 * B + R + 3);
    do_reset();
    step(1'b0, 4'd0);
    chk("rerun_gap_an", {5'b0, bus.an}, 7'h03);
    step(1'b0, 4'd0);
    chk("rerun_ones_seg", bus.seg, 7'h40);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cnt = cnt + 4'd1;
        step(1'b1, cnt);
      end else begin
        step(1'b0, 4'($urandom_range(0, 15)));
      end
    end
    for (int i = 0; i < 800; i++) step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
    do_reset();
    idle(P + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
